// File: rtl/parity_pkg.sv
// Shared types and helpers for the streaming parity frame generator.
package parity_pkg;

  typedef enum logic {
    ST_DATA    = 1'b0,
    ST_TRAILER = 1'b1
  } state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Word-counter width; a one-word frame still needs a 1-bit counter.
  function automatic int cnt_width(input int frame_len);
    return (frame_len <= 1) ? 1 : $clog2(frame_len);
  endfunction

endpackage

// File: rtl/parity_word.sv
// Row parity of one word: XOR-reduce of the bits, flipped for odd mode.
module parity_word #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] word,
  input  logic              mode,
  output logic              parity
);

  assign parity = (^word) ^ mode;

endmodule

// File: rtl/parity_frame_gen.sv
// Streaming row/column parity encoder: each word gets a row parity bit and every
// FRAME_LEN words are followed by a column-parity trailer. Optional: PARITY_ERR_INJECT_EN.
module parity_frame_gen
  import parity_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              odd_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_parity,
  output logic              out_trailer
`ifdef PARITY_ERR_INJECT_EN
  ,
  input  logic              err_inject
`endif
);

  localparam int              CNT_W = cnt_width(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME_LEN - 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   acc;
  logic                mode_q;

  logic                out_free;
  logic                accept;
  logic                first_word;
  logic                mode_eff;
  logic                inj;
  logic                data_parity;
  logic [DATA_W-1:0]   trailer_word;
  logic                trailer_parity;

  // Output register may be reloaded when empty or being drained this cycle.
  assign out_free   = !out_valid || out_ready;
  assign in_ready   = (state == ST_DATA) && out_free;
  assign accept     = in_valid && in_ready;
  assign first_word = (cnt == '0);

  // The first word of a frame uses the live mode; the rest use the latched one.
  assign mode_eff     = first_word ? odd_mode : mode_q;
  assign trailer_word = acc ^ {DATA_W{mode_q}};

`ifdef PARITY_ERR_INJECT_EN
  assign inj = err_inject;
`else
  assign inj = 1'b0;
`endif

  parity_word #(.DATA_W(DATA_W)) u_data_par (
    .word   (in_data),
    .mode   (mode_eff),
    .parity (data_parity)
  );

  parity_word #(.DATA_W(DATA_W)) u_trailer_par (
    .word   (trailer_word),
    .mode   (mode_q),
    .parity (trailer_parity)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_DATA;
      cnt         <= '0;
      acc         <= '0;
      mode_q      <= PARITY_EVEN;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_parity  <= 1'b0;
      out_trailer <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        ST_DATA: begin
          if (accept) begin
            out_valid   <= 1'b1;
            out_data    <= in_data;
            out_parity  <= data_parity ^ inj;
            out_trailer <= 1'b0;
            if (first_word) begin
              mode_q <= odd_mode;
              acc    <= in_data;
            end else begin
              acc    <= acc ^ in_data;
            end
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= ST_TRAILER;
            end else begin
              cnt   <= cnt + 1'b1;
            end
          end
        end

        ST_TRAILER: begin
          // Trailer takes one output slot, then the next frame may start.
          if (out_free) begin
            out_valid   <= 1'b1;
            out_data    <= trailer_word;
            out_parity  <= trailer_parity;
            out_trailer <= 1'b1;
            state       <= ST_DATA;
          end
        end

        default: state <= ST_DATA;
      endcase
    end
  end

endmodule
